rr_reg_arbiter: RTL and testbench
=================================

Name: rr_reg_arbiter

Overview:
- Round-robin arbiter that shares one enabled pipeline register among NREQ requesters.
- Each cycle it selects at most one requester and drives that requester's data plus an enable into an internal output register (enable-flop semantics).
- The registered word is presented downstream with a valid/ready handshake.
- Used wherever several units contend for a single write slot, e.g. a shared writeback or bus-request register.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 32, data width per requester in bits.
- IDW, $clog2(NREQ), width of the grant index (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  bit i: requester i has a word.
- req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  bit i: requester i's word is accepted this cycle.
- out_valid  output  1  output register holds a valid word.
- out_data  output  WIDTH  registered word.
- out_id  output  IDW  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid=0, out_data=0, out_id=0.
  - Priority pointer ptr=0; state=EMPTY.
  - req_ready=0 combinationally while reset_n is low.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = (state==EMPTY) | out_ready. When load=1 the output register can take a new word this cycle (pass-through when full and draining).
- Winner: the first i with req_valid[i]=1, scanning circularly from ptr: ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
- req_ready is one-hot or zero.
  - req_ready[w]=1 only when load=1 and w is the winner.
  - req_ready is a combinational function of req_valid, ptr, state and out_ready.
- Transfer from requester w: req_valid[w] & req_ready[w]. On that clock edge:
  - out_data<=req_data[w]; out_id<=w; out_valid<=1; state->FULL.
  - ptr<=(w+1) mod NREQ. Wrap: w=NREQ-1 gives ptr=0.
- Drain without refill (out_ready=1 and no req_valid): out_valid<=0, state->EMPTY. out_data and out_id hold their values (do not care).
- FULL and out_ready=0: register holds; out_data, out_id and out_valid are stable. All req_ready=0 (backpressure). ptr unchanged.
- Simultaneous drain and fill (FULL, out_ready=1, winner present): new word loads on the same edge and out_valid stays 1. This gives a full-throughput stream of one word per cycle.
- No valid requests: ptr unchanged. No grant is ever issued to an invalid requester.
- Latency: one cycle, from an accepted request to out_valid.
- Fairness: a continuously-valid requester waits at most NREQ-1 transfers.
- Requester-side rules: a requester must hold req_valid and req_data stable until accepted. The arbiter does not check this.
- Reset mid-transfer: any held word is discarded; the arbiter restarts from ptr=0.
- NREQ not a power of two: ptr and winner values are always < NREQ. The wrap is explicit, not a natural overflow.

Decomposition:
- Package rr_arb_pkg: state enum (EMPTY, FULL) and a helper function for the circular first-one search.
- Sub-module rr_pick (combinational): inputs req_valid and ptr; outputs one-hot grant, found, and winner index.
- The top level holds the state register, ptr register and enable-gated output register, plus the data mux.

Test Plan:
- Reset then all idle: reset_n low at arbitrary state -> out_valid=0, out_data=0, req_ready=0, ptr=0. Release with req_valid=0000 for 5 cycles -> nothing changes.
- Single requester: req_valid=0100, req_data[2]=0xDEADBEEF, out_ready=1 ->
  - req_ready=0100 in that cycle.
  - Next cycle: out_valid=1, out_data=0xDEADBEEF, out_id=2.
  - ptr=3.
- Rotation under contention: req_valid=1111 held, out_ready=1 -> grants in order 0,1,2,3,0,1; out_valid stays 1 every cycle after the first.
- Backpressure: FULL with out_ready=0 for 4 cycles while req_valid=0011 -> req_ready=0000. out_data/out_id stable. Release out_ready -> requester at ptr is granted next.
- Wrap and skip: ptr=3, req_valid=1001 -> requester 3 granted and ptr=0. Next grant is 0, then 3.
- Async reset mid-stream: assert reset_n low between clock edges while FULL -> out_valid drops immediately. After release, the first grant follows ptr=0 order.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and the circular first-one search used by the round-robin arbiter.
package rr_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned MAX_IDW = 4;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } pick_t;

    // Scan ptr, ptr+1, ... circularly over n requesters; the wrap is an explicit
    // subtraction so non-power-of-two n never yields an index >= n.
    function automatic pick_t rr_first(input logic [MAX_REQ-1:0] valid,
                                       input logic [MAX_IDW-1:0] ptr,
                                       input int unsigned        n);
        pick_t       r;
        int unsigned s;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            s = {28'd0, ptr} + k;
            if (s >= n) s = s - n;
            if ((k < n) && !r.found && valid[s[MAX_IDW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = s[MAX_IDW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: one-hot grant plus winner index from a priority pointer.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic            found,
    output logic [IDW-1:0]  winner
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_IDW-1:0] ptr_ext;
    pick_t              pick;

    always_comb begin
        valid_ext              = '0;
        valid_ext[NREQ-1:0]    = req_valid;
        ptr_ext                = MAX_IDW'(ptr);
        pick                   = rr_first(valid_ext, ptr_ext, NREQ);
        found                  = pick.found;
        winner                 = IDW'(pick.idx);
        grant                  = '0;
        if (pick.found) grant  = NREQ'(1) << winner;
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter feeding one enable-flop output register with a valid/ready handshake.
module rr_reg_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_id,
    input  logic                  out_ready
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q;
    logic [IDW-1:0]   id_q;

    logic [NREQ-1:0]  grant;
    logic             found;
    logic [IDW-1:0]   winner;
    logic             load;
    logic             xfer;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .found     (found),
        .winner    (winner)
    );

    // The register may refill whenever it is empty or is being drained this cycle.
    assign load      = (state_q == EMPTY) | out_ready;
    assign xfer      = load & found;
    assign req_ready = (reset_n & load) ? grant : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (found) begin
                state_d = FULL;
                ptr_d   = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            id_q   <= '0;
        end else if (xfer) begin
            data_q <= req_data[winner*WIDTH +: WIDTH];
            id_q   <= winner;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Randomized and directed bench for rr_reg_arbiter against a queue-free behavioural model.
module tb_rr_reg_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int               m_ptr   = 0;
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_id    = 0;
    logic [NREQ-1:0]  m_acc   = '0;

    rr_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick_winner(input logic [NREQ-1:0] v, input int p);
        for (int j = 0; j < NREQ; j++) begin
            int idx;
            idx = (p + j) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int w;
        if (!reset_n) return '0;
        if (m_valid && !out_ready) return '0;
        w = pick_winner(req_valid, m_ptr);
        if (w < 0) return '0;
        return NREQ'(1) << w;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 0;
            m_acc   = '0;
        end else begin
            int w;
            m_acc = '0;
            if (!m_valid || out_ready) begin
                w = pick_winner(req_valid, m_ptr);
                if (w >= 0) begin
                    m_data   = req_data[w*WIDTH +: WIDTH];
                    m_id     = w;
                    m_valid  = 1'b1;
                    m_ptr    = (w + 1) % NREQ;
                    m_acc[w] = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", 32'(req_ready), 32'(exp_ready()));
        chk("valid", 32'(out_valid), 32'(m_valid));
        if (m_valid || !reset_n) begin
            chk("data", out_data, m_data);
            chk("id", 32'(out_id), m_id);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refresh_data();
        for (int i = 0; i < NREQ; i++)
            if (m_acc[i]) req_data[i*WIDTH +: WIDTH] = $urandom;
    endtask

    int               rot_seq  [6] = '{0, 1, 2, 3, 0, 1};
    int               wrap_seq [3] = '{3, 0, 3};
    logic [WIDTH-1:0] held_data;

    initial begin
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = $urandom;

        // Reset with everything requesting
        req_valid = 4'b1111;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_valid", 32'(out_valid), 32'h0);
            chk("rst_data", out_data, 32'h0);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        reset_n   = 1'b1;
        repeat (5) tick();
        chk("idle_valid", 32'(out_valid), 32'h0);
        chk("idle_ptr", m_ptr, 0);

        // Single requester
        req_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data", out_data, 32'hDEADBEEF);
        chk("single_id", 32'(out_id), 32'h2);
        chk("single_ptr", m_ptr, 3);
        tick();

        // Wrap and skip from ptr=3
        req_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wrap_grant", 32'(req_ready), 32'(1) << wrap_seq[i]);
            tick();
            refresh_data();
        end
        req_valid = '0;
        tick();
        chk("wrap_ptr", m_ptr, 0);

        // Full contention rotation
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rot_grant", 32'(req_ready), 32'(1) << rot_seq[i]);
            if (i > 0) chk("rot_valid", 32'(out_valid), 32'h1);
            tick();
            refresh_data();
        end

        // Backpressure while FULL with id=1, ptr=2
        req_valid = 4'b0011;
        out_ready = 1'b0;
        held_data = m_data;
        repeat (4) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_id", 32'(out_id), 32'h1);
            chk("bp_data", out_data, held_data);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(req_ready), 32'h1);
        tick();
        refresh_data();
        @(negedge clk);
        chk("bp_next", 32'(req_ready), 32'h2);
        tick();
        refresh_data();

        // Randomized traffic with requesters holding until accepted
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || m_acc[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_data[i*WIDTH +: WIDTH] = $urandom;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Asynchronous reset while FULL
        req_valid = 4'b1111;
        out_ready = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'h0);
        chk("async_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        tick();
        @(negedge clk);
        chk("post_rst_grant2", 32'(req_ready), 32'h2);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
